// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending register writes and raises ID-stage stalls.
// Optional macro SCOREBOARD_FWD_EN: when defined, only a load-use at age 0 stalls; otherwise any hit stalls.
module reg_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        issue_reg_write,
  input  logic        issue_mem_read,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        PCwrite,
  output logic        IF_ID_write,
  output logic        is_hazard,
  output logic [31:0] busy_vec,
  output logic        wb_err
);

  logic [31:0]      busy_q, busy_d;
  logic [31:0]      load_q, load_d;
  logic [31:0][1:0] age_q, age_d;
  logic             wb_err_d;

  logic issue_acc;
  logic wb_act;
  logic wb_err_set;
  logic hit1, hit2;
  logic stall1, stall2;

  // Source hits: x0 is never busy, but the explicit check keeps it out of the path.
  assign hit1 = use_rs1 && (rs1_ID != 5'd0) && busy_q[rs1_ID];
  assign hit2 = use_rs2 && (rs2_ID != 5'd0) && busy_q[rs2_ID];

`ifdef SCOREBOARD_FWD_EN
  assign stall1 = hit1 && load_q[rs1_ID] && (age_q[rs1_ID] == 2'd0);
  assign stall2 = hit2 && load_q[rs2_ID] && (age_q[rs2_ID] == 2'd0);
`else
  assign stall1 = hit1;
  assign stall2 = hit2;
`endif

  assign is_hazard   = stall1 || stall2;
  assign PCwrite     = ~is_hazard;
  assign IF_ID_write = ~is_hazard;
  assign busy_vec    = busy_q;

  assign issue_acc  = issue_valid && !is_hazard && issue_reg_write && (issue_rd != 5'd0);
  assign wb_act     = wb_valid && (wb_rd != 5'd0);
  assign wb_err_set = wb_act && !busy_q[wb_rd] && !(issue_acc && (issue_rd == wb_rd));

  always_comb begin
    busy_d   = busy_q;
    load_d   = load_q;
    age_d    = age_q;
    wb_err_d = wb_err || wb_err_set;
    for (int r = 1; r < 32; r++) begin
      if (issue_acc && (issue_rd == 5'(r))) begin
        // Issue wins over a same-cycle writeback to the same register.
        busy_d[r] = 1'b1;
        load_d[r] = issue_mem_read;
        age_d[r]  = 2'd0;
      end else if (wb_act && (wb_rd == 5'(r))) begin
        busy_d[r] = 1'b0;
        load_d[r] = 1'b0;
        age_d[r]  = 2'd0;
      end else if (busy_q[r] && (age_q[r] != 2'd3)) begin
        age_d[r] = age_q[r] + 2'd1;
      end
    end
    busy_d[0] = 1'b0;
    load_d[0] = 1'b0;
    age_d[0]  = 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      load_q <= '0;
      age_q  <= '0;
      wb_err <= 1'b0;
    end else begin
      busy_q <= busy_d;
      load_q <= load_d;
      age_q  <= age_d;
      wb_err <= wb_err_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard; expectations follow SCOREBOARD_FWD_EN.
module tb_reg_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_reg_write, issue_mem_read;
  logic [4:0]  issue_rd, rs1_ID, rs2_ID, wb_rd;
  logic        use_rs1, use_rs2, wb_valid;
  logic        PCwrite, IF_ID_write, is_hazard, wb_err;
  logic [31:0] busy_vec;

  int total = 0;
  int bad   = 0;

`ifdef SCOREBOARD_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  reg_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_reg_write(issue_reg_write), .issue_mem_read(issue_mem_read),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .PCwrite(PCwrite), .IF_ID_write(IF_ID_write), .is_hazard(is_hazard),
    .busy_vec(busy_vec), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_haz(input string tag, input logic exp);
    chk({tag, "_haz"}, {31'd0, is_hazard}, {31'd0, exp});
    chk({tag, "_pc"},  {31'd0, PCwrite},   {31'd0, ~exp});
  endtask

  initial begin
    reset = 1'b0;
    issue_valid = 0; issue_rd = 0; issue_reg_write = 0; issue_mem_read = 0;
    rs1_ID = 0; rs2_ID = 0; use_rs1 = 0; use_rs2 = 0; wb_valid = 0; wb_rd = 0;
    #12;
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_haz", {31'd0, is_hazard}, 32'd0);
    reset = 1'b1;
    tick();

    // Idle after reset
    #1;
    chk("idle_busy", busy_vec, 32'd0);
    chk("idle_pc", {31'd0, PCwrite}, 32'd1);
    chk("idle_ifid", {31'd0, IF_ID_write}, 32'd1);
    chk("idle_haz", {31'd0, is_hazard}, 32'd0);
    chk("idle_err", {31'd0, wb_err}, 32'd0);

    // ALU producer rd=5, consumer on rs1 next cycle, writeback at age 2
    issue_valid = 1; issue_rd = 5; issue_reg_write = 1; issue_mem_read = 0;
    tick();
    issue_valid = 0; rs1_ID = 5; use_rs1 = 1;
    #1;
    chk("alu_busy", busy_vec, 32'h0000_0020);
    chk_haz("alu_c0", ~FWD);
    tick();
    #1;
    chk_haz("alu_c1", ~FWD);
    tick();
    wb_valid = 1; wb_rd = 5;
    #1;
    chk_haz("alu_c2", ~FWD);
    tick();
    wb_valid = 0;
    #1;
    chk_haz("alu_c3", 1'b0);
    chk("alu_clr", busy_vec, 32'd0);
    chk("alu_err", {31'd0, wb_err}, 32'd0);
    use_rs1 = 0;

    // Load producer rd=7, consumer on rs2
    issue_valid = 1; issue_rd = 7; issue_mem_read = 1;
    tick();
    issue_valid = 0; issue_mem_read = 0; rs2_ID = 7; use_rs2 = 1;
    #1;
    chk_haz("ld_c0", 1'b1);
    tick();
    #1;
    chk_haz("ld_c1", ~FWD);
    tick();
    wb_valid = 1; wb_rd = 7;
    #1;
    chk_haz("ld_c2", ~FWD);
    tick();
    wb_valid = 0; use_rs2 = 0;
    #1;
    chk("ld_clr", busy_vec, 32'd0);
    chk_haz("ld_c3", 1'b0);

    // Same-cycle issue (load) and writeback on rd=3: issue wins, age 0
    issue_valid = 1; issue_rd = 3; issue_mem_read = 1; wb_valid = 1; wb_rd = 3;
    tick();
    issue_valid = 0; issue_mem_read = 0; wb_valid = 0;
    rs1_ID = 3; use_rs1 = 1;
    #1;
    chk("col_busy", busy_vec, 32'h0000_0008);
    chk("col_err", {31'd0, wb_err}, 32'd0);
    chk_haz("col_age0", 1'b1);
    tick();
    #1;
    chk_haz("col_age1", ~FWD);
    wb_valid = 1; wb_rd = 3;
    tick();
    wb_valid = 0; use_rs1 = 0;
    #1;
    chk("col_clr", busy_vec, 32'd0);
    chk("col_err2", {31'd0, wb_err}, 32'd0);

    // Spurious writeback to idle reg 9 sets sticky error
    wb_valid = 1; wb_rd = 9;
    tick();
    wb_valid = 0;
    #1;
    chk("err_set", {31'd0, wb_err}, 32'd1);
    tick();
    #1;
    chk("err_hold", {31'd0, wb_err}, 32'd1);

    // Issue to x0 never becomes busy or hazards
    issue_valid = 1; issue_rd = 0; issue_reg_write = 1;
    rs1_ID = 0; use_rs1 = 1;
    tick();
    issue_valid = 0;
    #1;
    chk("x0_busy", busy_vec, 32'd0);
    chk_haz("x0", 1'b0);
    use_rs1 = 0;

    // Regs 4 and 6 busy, then async reset mid-cycle
    issue_valid = 1; issue_rd = 4;
    tick();
    issue_rd = 6;
    tick();
    issue_valid = 0; rs1_ID = 4; use_rs1 = 1;
    #1;
    chk("pre_rst_busy", busy_vec, 32'h0000_0050);
    chk_haz("pre_rst", ~FWD);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy_vec, 32'd0);
    chk_haz("arst", 1'b0);
    chk("arst_err", {31'd0, wb_err}, 32'd0);
    #1;
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL expose these ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- issue_valid  in  1  ID instruction advances into EX this cycle.
- issue_rd  in  5  destination register of the issuing instruction.
- issue_reg_write  in  1  issuing instruction writes rd.
- issue_mem_read  in  1  issuing instruction is a load.
- rs1_ID  in  5  ID source register 1.
- rs2_ID  in  5  ID source register 2.
- use_rs1  in  1  ID instruction reads rs1.
- use_rs2  in  1  ID instruction reads rs2.
- wb_valid  in  1  WB stage writes the register file this cycle.
- wb_rd  in  5  WB destination register.
- PCwrite  out  1  PC update enable.
- IF_ID_write  out  1  IF/ID register write enable.
- is_hazard  out  1  insert bubble into ID/EX.
- busy_vec  out  32  per-register pending-write bits; bit 0 always 0.
- wb_err  out  1  sticky: writeback to a register that was not busy.

Function
REQ-003 Each register r in 1..31 SHALL hold a busy bit, a load bit and a 2-bit age (0 = producer in EX, 1 = MEM, 2 = WB, 3 = saturated).
REQ-004 An accepted issue is issue_valid=1, is_hazard=0, issue_reg_write=1 and issue_rd!=0. On an accepted issue, the entry for issue_rd SHALL be set at the next edge: busy=1, age=0, load=issue_mem_read.
REQ-005 issue_valid SHALL be ignored while is_hazard=1.
REQ-006 Every busy entry not being issued SHALL increment its age by one per cycle, saturating at 3.
REQ-007 wb_valid=1 with wb_rd!=0 SHALL clear busy for wb_rd at the next edge.
REQ-008 If an accepted issue and a writeback target the same rd in the same cycle, the issue SHALL win: busy=1, age=0.
REQ-009 A writeback with wb_rd!=0 whose entry is not busy, and which does not collide with a same-cycle accepted issue to that rd, SHALL set wb_err=1 at the next edge; wb_err SHALL stay 1 until reset.
REQ-010 Register x0 SHALL never become busy and SHALL never cause a hazard.
REQ-011 A source s (rs1_ID or rs2_ID) SHALL be "hit" when its use bit is 1, s!=0 and busy[s]=1.
REQ-012 Hazard outputs SHALL be combinational from current state and ID inputs: is_hazard=1 and PCwrite=IF_ID_write=0 when a stall condition (REQ-016) holds; otherwise is_hazard=0 and PCwrite=IF_ID_write=1.
REQ-013 busy_vec SHALL reflect the registered busy bits with zero added latency.

Reset
REQ-014 While reset=0, all busy, load and age bits SHALL be 0, wb_err=0 and busy_vec=0. As a consequence, PCwrite=1, IF_ID_write=1 and is_hazard=0.
REQ-015 Reset asserted mid-operation SHALL discard all pending entries immediately, independent of clk.

Configuration
REQ-016 The macro SCOREBOARD_FWD_EN SHALL select the stall condition:
- Defined: stall only if a hit source is a load entry at age 0 (one-cycle load-use bubble). ALU results are assumed forwarded.
- Undefined: stall on any hit source, including the writeback cycle, because there is no internal register-file forwarding. Stall persists until busy clears.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset, then idle: busy_vec=0, PCwrite=1, IF_ID_write=1, is_hazard=0, wb_err=0.
- ALU issue to rd=5, next cycle rs1_ID=5, use_rs1=1; no wb until age 2 -> macro off: is_hazard=1 for 3 cycles; macro on: is_hazard=0.
- Load issue to rd=7, next cycle rs2_ID=7, use_rs2=1 -> macro on: exactly one cycle is_hazard=1, then 0.
- Issue rd=3 with wb_valid=1, wb_rd=3 in the same cycle -> busy_vec[3]=1, age 0, wb_err=0.
- wb_valid=1, wb_rd=9 with reg 9 idle -> wb_err=1 next cycle and held; issue to rd=0 -> busy_vec stays 0.
- Reset asserted while regs 4 and 6 are busy -> busy_vec=0 immediately, is_hazard=0.
